// File: rtl/stage_ir_superscalar_pkg.sv
// Shared types for the in-order retire stage:
// ROB head packets, writeback packets and store buffer entries.
package stage_ir_superscalar_pkg;

    localparam int XLEN     = 32;
    localparam int PRF_SIZE = 64;
    localparam int TAG_W    = $clog2(PRF_SIZE);
    localparam int REG_W    = 5;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic [3:0] {
        NO_ERROR          = 4'h0,
        HALTED_ON_WFI     = 4'h1,
        LOAD_ACCESS_FAULT = 4'h2,
        ILLEGAL_INST      = 4'h3
    } EXCEPTION_CODE;

    typedef struct packed {
        logic             retire_en;
        logic [TAG_W-1:0] retire_t;
        logic [TAG_W-1:0] retire_t_old;
        logic [REG_W-1:0] dest_reg_idx;
        logic             is_store;
        logic             is_halt;
        logic             take_branch;
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  rs2_value;
        logic [2:0]       funct3;
        logic [XLEN-1:0]  NPC;
    } ROB_IR_PACKET;

    typedef struct packed {
        logic [TAG_W-1:0] retire_t;
        logic [TAG_W-1:0] retire_t_old;
        logic             retire_en;
    } IR_TAG_PACKET;

    typedef IR_TAG_PACKET IR_FL_PACKET;
    typedef IR_TAG_PACKET IR_MT_PACKET;

    typedef struct packed {
        logic             wr_en;
        logic [REG_W-1:0] wr_idx;
        logic [XLEN-1:0]  wr_data;
        logic [XLEN-1:0]  NPC;
    } IR_PIPELINE_PACKET;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        MEM_SIZE         size;
    } SB_ENTRY;

endpackage

// File: rtl/stage_ir_superscalar_store_buffer.sv
// Retired-store FIFO: several in-order pushes per cycle,
// one pop per cycle, head reads zero while empty.
module retire_store_buffer
    import stage_ir_superscalar_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PUSH_W = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push_valid [PUSH_W],
    input  SB_ENTRY                    push_entry [PUSH_W],
    input  logic                       pop,
    output SB_ENTRY                    head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    SB_ENTRY       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] slot_idx [PUSH_W];
    logic [CW-1:0] push_n;
    logic          pop_q;
    int            n;

    // compact valid pushes into consecutive slots after the tail
    always_comb begin
        n = 0;
        for (int i = 0; i < PUSH_W; i++) begin
            slot_idx[i] = wr_ptr + PW'(n);
            if (push_valid[i]) n = n + 1;
        end
        push_n = CW'(n);
        pop_q  = pop && (count != '0);
        head   = (count != '0) ? mem[rd_ptr] : '0;
    end

    // pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop_q);
            count  <= count + push_n - CW'(pop_q);
        end
    end

    // entry storage; validity is tracked by count alone
    always_ff @(posedge clock) begin
        for (int i = 0; i < PUSH_W; i++) begin
            if (push_valid[i]) mem[slot_idx[i]] <= push_entry[i];
        end
    end

endmodule

// File: rtl/stage_ir_superscalar.sv
// Superscalar in-order retire: commits the ROB head, updates
// free list / map table, and buffers retired stores for Dmem.
module stage_ir_superscalar
    import stage_ir_superscalar_pkg::*;
#(
    parameter int RETIRE_WIDTH = 2,
    parameter int SB_DEPTH     = 4
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  ROB_IR_PACKET                      rob_ir_packet [RETIRE_WIDTH],
    input  logic [XLEN-1:0]                   prf_read_out [RETIRE_WIDTH],
    input  logic                              dmem_store_grant,
    output logic [$clog2(RETIRE_WIDTH+1)-1:0] retire_count,
    output logic [TAG_W-1:0]                  prf_read_tag [RETIRE_WIDTH],
    output IR_FL_PACKET                       ir_fl_packet [RETIRE_WIDTH],
    output IR_MT_PACKET                       ir_mt_packet [RETIRE_WIDTH],
    output IR_PIPELINE_PACKET                 pipe_packet [RETIRE_WIDTH],
    output logic [3:0]                        completed_insts,
    output EXCEPTION_CODE                     error_status,
    output logic                              interrupt,
    output logic [XLEN-1:0]                   branch_target,
    output BUS_COMMAND                        store2Dmem_command,
    output MEM_SIZE                           store2Dmem_size,
    output logic [XLEN-1:0]                   store2Dmem_addr,
    output logic [XLEN-1:0]                   store2Dmem_data,
    output logic [$clog2(SB_DEPTH+1)-1:0]     sb_count
);

    localparam int RCW = $clog2(RETIRE_WIDTH+1);

    logic    accepted   [RETIRE_WIDTH];
    logic    push_valid [RETIRE_WIDTH];
    SB_ENTRY push_entry [RETIRE_WIDTH];
    SB_ENTRY head;
    logic    pop;
    logic    stop;
    logic    wr;
    logic    unused_funct3;
    int      n_st;
    int      n_ret;
    int      free;

    // in-order slot scan; stalls on full buffer, halts and branches
    always_comb begin
        stop          = 1'b0;
        n_st          = 0;
        n_ret         = 0;
        free          = SB_DEPTH - int'(sb_count);
        interrupt     = 1'b0;
        branch_target = '0;
        error_status  = NO_ERROR;
        unused_funct3 = 1'b0;
        wr            = 1'b0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            accepted[i]     = 1'b0;
            prf_read_tag[i] = rob_ir_packet[i].retire_t;
            unused_funct3   = unused_funct3 ^ rob_ir_packet[i].funct3[2];
            if (!stop) begin
                if (!rob_ir_packet[i].retire_en) begin
                    stop = 1'b1;
                end else if (rob_ir_packet[i].is_store && n_st >= free) begin
                    stop = 1'b1;
                end else if (rob_ir_packet[i].is_halt &&
                             (sb_count != '0 || n_st != 0)) begin
                    stop = 1'b1;
                end else begin
                    accepted[i] = 1'b1;
                    n_ret       = n_ret + 1;
                    if (rob_ir_packet[i].is_store) n_st = n_st + 1;
                    if (rob_ir_packet[i].take_branch) begin
                        interrupt     = 1'b1;
                        branch_target = rob_ir_packet[i].result;
                        stop          = 1'b1;
                    end
                    if (rob_ir_packet[i].is_halt) begin
                        error_status = HALTED_ON_WFI;
                        stop         = 1'b1;
                    end
                end
            end
            wr = accepted[i] && (rob_ir_packet[i].dest_reg_idx != ZERO_REG);
            ir_fl_packet[i] = '0;
            pipe_packet[i]  = '0;
            if (accepted[i]) begin
                ir_fl_packet[i].retire_t     = rob_ir_packet[i].retire_t;
                ir_fl_packet[i].retire_t_old = rob_ir_packet[i].retire_t_old;
                ir_fl_packet[i].retire_en    = wr;
                pipe_packet[i].wr_en         = wr;
                pipe_packet[i].wr_idx        = rob_ir_packet[i].dest_reg_idx;
                pipe_packet[i].wr_data       = prf_read_out[i];
                pipe_packet[i].NPC           = rob_ir_packet[i].NPC;
            end
            ir_mt_packet[i]     = ir_fl_packet[i];
            push_valid[i]       = accepted[i] && rob_ir_packet[i].is_store;
            push_entry[i].addr  = rob_ir_packet[i].result;
            push_entry[i].data  = rob_ir_packet[i].rs2_value;
            push_entry[i].size  = MEM_SIZE'(rob_ir_packet[i].funct3[1:0]);
        end
        retire_count    = RCW'(n_ret);
        completed_insts = 4'(retire_count);
    end

    // Dmem store port driven from the buffer head
    always_comb begin
        store2Dmem_command = (sb_count != '0) ? BUS_STORE : BUS_NONE;
        store2Dmem_size    = head.size;
        store2Dmem_addr    = head.addr;
        store2Dmem_data    = head.data;
        pop = (store2Dmem_command == BUS_STORE) && dmem_store_grant;
    end

    retire_store_buffer #(
        .DEPTH  (SB_DEPTH),
        .PUSH_W (RETIRE_WIDTH)
    ) u_sb (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_valid (push_valid),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (sb_count)
    );

endmodule
